// File: rtl/rtn_addr_stack.sv
// Return-address stack for the 8-bit CPU: call pushes, return pops, and the top
// of stack feeds the program counter combinationally from registered state.
module rtn_addr_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic          clr_err,
    output logic [AW-1:0] return_addr,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ovrflw,
    output logic          undrflw
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] stack_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          ovrflw_q, ovrflw_d;
    logic          undrflw_q, undrflw_d;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = IW'(count_q - CW'(1));

    // Next-state: write slot, occupancy and sticky error flags.
    always_comb begin
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_idx    = IW'(count_q);
        ovrflw_d  = ovrflw_q & ~clr_err;
        undrflw_d = undrflw_q & ~clr_err;
        if (push && pop) begin
            wr_en = 1'b1;
            if (is_empty) begin
                // Return on an empty stack still records the new call.
                undrflw_d = 1'b1;
                wr_idx    = '0;
                count_d   = CW'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (is_full) begin
                ovrflw_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                undrflw_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            ovrflw_q  <= 1'b0;
            undrflw_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            ovrflw_q  <= ovrflw_d;
            undrflw_q <= undrflw_d;
        end
    end

    // Entry storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= push_addr;
        end
    end

    assign return_addr = is_empty ? '0 : stack_q[top_idx];
    assign empty       = is_empty;
    assign full        = is_full;
    assign count       = count_q;
    assign ovrflw      = ovrflw_q;
    assign undrflw     = undrflw_q;

endmodule

// File: tb/tb_rtn_addr_stack.sv
// Self-checking bench for rtn_addr_stack: vector table, directed corner
// sequences, a call/return with a program-counter model, and random traffic.
module tb_rtn_addr_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push, pop, clr_err;
    logic [AW-1:0] push_addr;
    logic [AW-1:0] return_addr;
    logic          empty, full, ovrflw, undrflw;
    logic [CW-1:0] count;

    // Program-counter model sitting downstream of the stack.
    logic          ld_rtn_addr, jmp;
    logic [AW-1:0] jmp_addr, pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rtn_addr_stack #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_addr  (push_addr),
        .clr_err    (clr_err),
        .return_addr(return_addr),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .ovrflw     (ovrflw),
        .undrflw    (undrflw)
    );

    always @(posedge clk) begin
        if (ld_rtn_addr)  pc <= return_addr;
        else if (jmp)     pc <= jmp_addr;
        else              pc <= pc + 8'd1;
    end

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] addr;
        logic [3:0] ecnt;
        logic [7:0] eret;
        logic       eovr;
        logic       eund;
    } vec_t;

    vec_t tbl [16];

    // Reference stack: plain queue plus sticky flags.
    logic [AW-1:0] mq [$];
    logic          m_ovr, m_und;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ecnt, input int eret,
                           input int eovr, input int eund);
        chk({tag, ".count"}, int'(count), ecnt);
        chk({tag, ".ret"}, int'(return_addr), eret);
        chk({tag, ".empty"}, int'(empty), int'(ecnt == 0));
        chk({tag, ".full"}, int'(full), int'(ecnt == DEPTH));
        chk({tag, ".ovr"}, int'(ovrflw), eovr);
        chk({tag, ".und"}, int'(undrflw), eund);
    endtask

    task automatic drive(input logic pu, input logic po, input logic cl, input logic [7:0] a);
        push = pu; pop = po; clr_err = cl; push_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic vec_t mk(logic pu, logic po, logic cl, logic [7:0] a,
                                logic [3:0] c, logic [7:0] r, logic o, logic u);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.addr = a;
        v.ecnt = c; v.eret = r; v.eovr = o; v.eund = u;
        return v;
    endfunction

    initial begin
        ld_rtn_addr = 1'b0; jmp = 1'b0; jmp_addr = 8'h00; pc = 8'h00;
        tbl[0]  = mk(1, 0, 0, 8'h10, 1, 8'h10, 0, 0);
        tbl[1]  = mk(1, 0, 0, 8'h21, 2, 8'h21, 0, 0);
        tbl[2]  = mk(1, 0, 0, 8'h32, 3, 8'h32, 0, 0);
        tbl[3]  = mk(0, 1, 0, 8'h00, 2, 8'h21, 0, 0);
        tbl[4]  = mk(0, 1, 0, 8'h00, 1, 8'h10, 0, 0);
        tbl[5]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        tbl[6]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[7]  = mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        tbl[8]  = mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[9]  = mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        tbl[10] = mk(1, 0, 0, 8'h10, 1, 8'h10, 0, 0);
        tbl[11] = mk(1, 0, 0, 8'h21, 2, 8'h21, 0, 0);
        tbl[12] = mk(1, 1, 0, 8'h99, 2, 8'h99, 0, 0);
        tbl[13] = mk(0, 1, 0, 8'h00, 1, 8'h10, 0, 0);
        tbl[14] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        tbl[15] = mk(1, 1, 0, 8'h99, 1, 8'h99, 0, 1);

        // Reset values.
        do_reset();
        chk_all("reset", 0, 0, 0, 0);

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].addr);
            tick();
            chk_all($sformatf("vec%0d", i), int'(tbl[i].ecnt), int'(tbl[i].eret),
                    int'(tbl[i].eovr), int'(tbl[i].eund));
        end

        // Fill to full, overflow, drain in LIFO order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
            tick();
        end
        chk_all("full", 8, 8'h47, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
        chk_all("ovf", 8, 8'h47, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            #2;
            chk($sformatf("popval%0d", i), int'(return_addr), 8'h47 - i);
            tick();
        end
        chk_all("drained", 0, 0, 1, 0);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk_all("clr_ovf", 0, 0, 0, 0);

        // Push-and-pop replaces the top when full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'hA5);
        tick();
        chk_all("full_replace", 8, 8'hA5, 0, 0);

        // Asynchronous reset mid-cycle with three entries.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h10 + 8'h11 * i));
            tick();
        end
        chk("pre_async.count", int'(count), 3);
        #2 reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Call/return against the PC model.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 8'h05);
        jmp = 1'b1; jmp_addr = 8'h80;
        tick();
        jmp = 1'b0;
        chk("call.pc", int'(pc), 8'h80);
        chk("call.ret", int'(return_addr), 8'h05);
        repeat (3) tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        ld_rtn_addr = 1'b1;
        tick();
        ld_rtn_addr = 1'b0;
        chk("ret.pc", int'(pc), 8'h05);
        chk("ret.count", int'(count), 0);

        // Random traffic against the queue model.
        do_reset();
        mq.delete(); m_ovr = 1'b0; m_und = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic pu, po, cl, ev_o, ev_u;
            logic [7:0] a;
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 99) < 8);
            a  = 8'($urandom);
            ev_o = 1'b0; ev_u = 1'b0;
            if (pu && po) begin
                if (mq.size() == 0) begin ev_u = 1'b1; mq.push_back(a); end
                else mq[mq.size() - 1] = a;
            end else if (pu) begin
                if (mq.size() == DEPTH) ev_o = 1'b1;
                else mq.push_back(a);
            end else if (po) begin
                if (mq.size() == 0) ev_u = 1'b1;
                else void'(mq.pop_back());
            end
            m_ovr = (m_ovr && !cl) || ev_o;
            m_und = (m_und && !cl) || ev_u;
            drive(pu, po, cl, a);
            tick();
            chk_all($sformatf("rnd%0d", n), mq.size(),
                    (mq.size() == 0) ? 0 : int'(mq[mq.size() - 1]),
                    int'(m_ovr), int'(m_und));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
